// File: rtl/oldland_pkg.sv
// Shared types for the Oldland hazard/sequencing control slice:
// FSM state encoding, scoreboard entry layout and register index width.
package oldland_pkg;

  localparam int unsigned REG_W = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_VECTOR = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } sb_entry_t;

  function automatic logic entry_match(input sb_entry_t e,
                                       input logic [REG_W-1:0] ra_sel,
                                       input logic uses_ra,
                                       input logic [REG_W-1:0] rb_sel,
                                       input logic uses_rb);
    return e.valid & ((uses_ra & (e.rd == ra_sel)) | (uses_rb & (e.rd == rb_sel)));
  endfunction

endpackage

// File: rtl/oldland_scoreboard.sv
// Three-entry destination-register scoreboard (execute, memory, writeback)
// that shifts each unfrozen cycle and reports source-register matches.
module oldland_scoreboard
  import oldland_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  sb_entry_t        push,
  input  logic [REG_W-1:0] ra_sel,
  input  logic [REG_W-1:0] rb_sel,
  input  logic             uses_ra,
  input  logic             uses_rb,
  output logic             match_e,
  output logic             match_m,
  output logic             match_w,
  output logic             e_is_load
);

  sb_entry_t ent_e, ent_m, ent_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_e <= '0;
      ent_m <= '0;
      ent_w <= '0;
    end else if (!freeze) begin
      ent_w <= ent_m;
      ent_m <= ent_e;
      ent_e <= push;
    end
  end

  always_comb begin
    match_e   = entry_match(ent_e, ra_sel, uses_ra, rb_sel, uses_rb);
    match_m   = entry_match(ent_m, ra_sel, uses_ra, rb_sel, uses_rb);
    match_w   = entry_match(ent_w, ra_sel, uses_ra, rb_sel, uses_rb);
    e_is_load = ent_e.is_load;
  end

endmodule

// File: rtl/oldland_hazard_ctrl.sv
// Oldland pipeline hazard/sequencing control: RAW stalls, branch flushes and
// exception drain/vector sequencing. OLDLAND_FORWARDING_EN selects load-use-only stalls.
module oldland_hazard_ctrl
  import oldland_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             d_valid,
  input  logic [REG_W-1:0] d_ra_sel,
  input  logic [REG_W-1:0] d_rb_sel,
  input  logic             d_uses_ra,
  input  logic             d_uses_rb,
  input  logic [REG_W-1:0] d_rd_sel,
  input  logic             d_update_rd,
  input  logic             d_mem_load,
  input  logic             e_branch_taken,
  input  logic             e_exception,
  input  logic             m_busy,
  output logic             stall_fetch,
  output logic             stall_decode,
  output logic             bubble_execute,
  output logic             flush_fetch,
  output logic             flush_decode,
  output logic             freeze,
  output logic             vector_load
);

  hz_state_t state, next_state;
  sb_entry_t push;
  logic      match_e, match_m, match_w, e_is_load, hazard;

  oldland_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .freeze    (freeze),
    .push      (push),
    .ra_sel    (d_ra_sel),
    .rb_sel    (d_rb_sel),
    .uses_ra   (d_uses_ra),
    .uses_rb   (d_uses_rb),
    .match_e   (match_e),
    .match_m   (match_m),
    .match_w   (match_w),
    .e_is_load (e_is_load)
  );

`ifdef OLDLAND_FORWARDING_EN
  logic unused_match;
  assign unused_match = match_m ^ match_w;
  assign hazard = match_e & e_is_load;
`else
  logic unused_load;
  assign unused_load = e_is_load;
  assign hazard = match_e | match_m | match_w;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= next_state;
  end

  // RUN-state actions are suppressed while memory is busy: the exception or
  // branch stays held in frozen execute and is acted on once it thaws.
  always_comb begin
    next_state     = state;
    stall_fetch    = 1'b0;
    stall_decode   = 1'b0;
    bubble_execute = 1'b0;
    flush_fetch    = 1'b0;
    flush_decode   = 1'b0;
    freeze         = 1'b0;
    vector_load    = 1'b0;
    if (!rst) begin
      case (state)
        ST_RUN: begin
          if (!m_busy) begin
            if (e_exception) begin
              flush_fetch    = 1'b1;
              flush_decode   = 1'b1;
              bubble_execute = 1'b1;
              next_state     = ST_DRAIN;
            end else if (e_branch_taken) begin
              flush_fetch  = 1'b1;
              flush_decode = 1'b1;
            end else if (hazard && d_valid) begin
              stall_fetch    = 1'b1;
              stall_decode   = 1'b1;
              bubble_execute = 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          flush_fetch  = 1'b1;
          flush_decode = 1'b1;
          stall_fetch  = 1'b1;
          if (!m_busy) next_state = ST_VECTOR;
        end
        ST_VECTOR: begin
          vector_load  = 1'b1;
          flush_decode = 1'b1;
          if (!m_busy) next_state = ST_RUN;
        end
        default: next_state = ST_RUN;
      endcase
      if (m_busy) begin
        freeze       = 1'b1;
        stall_fetch  = 1'b1;
        stall_decode = 1'b1;
      end
    end
  end

  always_comb begin
    push.valid   = d_valid & d_update_rd & ~stall_decode & ~flush_decode & ~bubble_execute;
    push.rd      = d_rd_sel;
    push.is_load = d_mem_load;
  end

endmodule

// File: doc/oldland_hazard_ctrl.md
# oldland_hazard_ctrl

Pipeline hazard and sequencing controller for the Oldland core. Sits beside the decode stage: tracks destination registers of in-flight instructions (execute, memory, writeback), stalls fetch/decode on read-after-write hazards, flushes younger stages on taken branches, and sequences exception entry by draining memory before loading the vector. It owns no datapath state; it only drives stall, flush and vector-load controls.

## Interface
- No parameters.
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- d_valid  in  1  decode stage holds a valid instruction (i_valid of decode).
- d_ra_sel, d_rb_sel  in  4 each  source register selects of the decode instruction.
- d_uses_ra, d_uses_rb  in  1 each  instruction reads ra / rb (alu_op1_ra, alu_op1_rb|alu_op2_rb|mem_store).
- d_rd_sel  in  4  destination register (r15 for calls).
- d_update_rd  in  1  instruction writes rd.
- d_mem_load  in  1  instruction is a load.
- e_branch_taken  in  1  execute resolved a taken branch/call/rfe this cycle.
- e_exception  in  1  execute holds an exception-starting instruction (illegal, swi).
- m_busy  in  1  memory stage waiting on bus/cache.
- stall_fetch, stall_decode  out  1 each  hold fetch PC / decode register.
- bubble_execute  out  1  insert no-op into execute.
- flush_fetch, flush_decode  out  1 each  invalidate fetched / decoded instruction.
- freeze  out  1  hold execute, memory and writeback.
- vector_load  out  1  fetch loads exception vector PC this cycle.

## Operation
- Scoreboard: three entries E, M, W, each {valid, rd[3:0], is_load}. When not frozen, per cycle: W<=M, M<=E, E<={d_valid & d_update_rd & ~stall_decode & ~flush_decode, d_rd_sel, d_mem_load}. freeze holds all entries.
- Match: entry matches if valid and rd equals d_ra_sel (with d_uses_ra) or d_rb_sel (with d_uses_rb).
- hazard: see Configuration. When hazard & d_valid & state RUN: stall_fetch=stall_decode=1, bubble_execute=1 (E entry written invalid).
- Taken branch (state RUN, no e_exception): flush_fetch=flush_decode=1 same cycle; E entry written invalid; overrides hazard stall.
- FSM states RUN, DRAIN, VECTOR.
  - RUN→DRAIN on e_exception (takes priority over e_branch_taken and hazard): flush_fetch, flush_decode, bubble_execute asserted.
  - DRAIN: flush_fetch, flush_decode, stall_fetch asserted; stays while m_busy; →VECTOR when m_busy=0.
  - VECTOR: vector_load=1, flush_decode=1 for one cycle; →RUN.
- m_busy in any state: freeze=stall_fetch=stall_decode=1; scoreboard and FSM (except DRAIN exit test) hold; flushes still assert in DRAIN.
- Reset mid-exception: returns to RUN, scoreboard cleared, no vector_load.

## Timing
- All outputs combinational from registered state plus current inputs; no output depends on its own previous value except via FSM.
- Reset values: FSM RUN, all scoreboard entries invalid, all outputs 0 while rst high (flushes not asserted in reset; decode already clears valid).
- Load-use stall (forwarding build): exactly 1 cycle. Non-forwarding build: stall until producer leaves W (up to 3 cycles).
- Exception entry latency: e_exception at cycle N → vector_load at N+2 if m_busy low at N+1; each busy cycle adds one.

## Configuration
- OLDLAND_FORWARDING_EN defined: hazard = match on E entry with is_load=1 only (ALU results forwarded from E/M/W).
- Undefined: hazard = match on any valid E, M or W entry.

## Structure
- Shared package oldland_pkg: FSM state encoding (RUN=0, DRAIN=1, VECTOR=2), scoreboard entry struct, register index width constant (4).
- One sub-module natural: oldland_scoreboard (three-entry shift with freeze, match outputs); FSM and output logic in top.

## Test plan
- LOAD r3 then ADD r4,r3,r5 (d_uses_ra, ra=3), forwarding build → stall_decode=1 one cycle, bubble_execute=1, second instr issues next cycle.
- Same sequence, non-forwarding build; also ALU producer r2 → consumer r2 → stall 3 cycles until W clears.
- e_branch_taken with d_valid → flush_fetch=flush_decode=1 same cycle, no stall even if hazard present.
- e_exception with m_busy high 3 cycles → DRAIN held 3 cycles, vector_load at 4th cycle after, then RUN.
- e_exception and e_branch_taken same cycle → DRAIN entered, no branch flush path taken, one vector_load.
- rst asserted during DRAIN → next cycle RUN, all outputs 0, scoreboard empty (no stall on following consumer of r3).
